// File: rtl/mult_result_deser_pkg.sv
// Shared types and constants for the multiplier result deserializer and the
// multiplier array that consumes bit_select.
package mult_result_deser_pkg;

    localparam int unsigned DEF_MAX_OUT_LEN  = 6;
    localparam int unsigned DEF_RESULT_WIDTH = 12;
    localparam int unsigned BSEL_W           = 3;
    localparam int unsigned BSEL_MAX         = (1 << BSEL_W) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2,
        ST_XFER = 2'd3
    } state_e;

    // Bit-position select saturates at the widest position the array decodes.
    function automatic logic [BSEL_W-1:0] sat_bsel(input int unsigned cnt);
        if (cnt > BSEL_MAX) begin
            return BSEL_W'(BSEL_MAX);
        end
        return BSEL_W'(cnt);
    endfunction

endpackage

// File: rtl/mult_row_shift.sv
// One result row: right-shifting capture register, new bits enter at the MSB
// so the first bit received ends up at the LSB.
module mult_row_shift #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {bit_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_result_deser.sv
// Collects bit-serial multiplier rows into a parallel result word, driving the
// bit-position select and handing the result off through a valid/ready register.
module mult_result_deser
    import mult_result_deser_pkg::*;
#(
    parameter int unsigned MAX_OUT_LEN  = DEF_MAX_OUT_LEN,
    parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic                                busy,
    output logic [BSEL_W-1:0]                   bit_select,
    input  logic [MAX_OUT_LEN-1:0]              serial_in,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [MAX_OUT_LEN*RESULT_WIDTH-1:0] res_data
);

    localparam int unsigned CNT_W = $clog2(RESULT_WIDTH + 1);

    state_e     state;
    state_e     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic        shift_clr;
    logic        shift_en;
    logic        load;
    logic        res_valid_next;
    logic        busy_next;
    logic [BSEL_W-1:0] bsel_next;

    logic [MAX_OUT_LEN-1:0][RESULT_WIDTH-1:0] row_q;

    // State register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(RESULT_WIDTH - 1)) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: begin
                state_next = ST_XFER;
            end
            ST_XFER: begin
                if (!res_valid || res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode; serial data lags bit_select by one cycle, so the first
    // RUN edge captures nothing and LAST picks up the final bit.
    always_comb begin
        shift_clr      = (state == ST_IDLE) && start;
        shift_en       = ((state == ST_RUN) && (cnt != '0)) || (state == ST_LAST);
        load           = (state == ST_XFER) && (!res_valid || res_ready);
        res_valid_next = res_valid;
        if (load) begin
            res_valid_next = 1'b1;
        end else if (res_ready) begin
            res_valid_next = 1'b0;
        end
        busy_next = (state_next != ST_IDLE);
        bsel_next = '0;
        if (state_next == ST_RUN) begin
            bsel_next = sat_bsel(32'(cnt_next));
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            bit_select <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            busy       <= busy_next;
            bit_select <= bsel_next;
            res_valid  <= res_valid_next;
            if (load) begin
                res_data <= row_q;
            end
        end
    end

    for (genvar r = 0; r < MAX_OUT_LEN; r++) begin : g_row
        mult_row_shift #(
            .WIDTH (RESULT_WIDTH)
        ) u_row (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (shift_clr),
            .shift_en (shift_en),
            .bit_in   (serial_in[r]),
            .q        (row_q[r])
        );
    end

endmodule

// File: tb/tb_mult_result_deser.sv
// Directed bench for mult_result_deser at default parameters (6 rows x 12 bits).
module tb_mult_result_deser;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [2:0]  bit_select;
    logic [5:0]  serial_in;
    logic        res_valid;
    logic        res_ready;
    logic [71:0] res_data;

    int vectors;
    int miscompares;

    mult_result_deser #(
        .MAX_OUT_LEN  (6),
        .RESULT_WIDTH (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .bit_select (bit_select),
        .serial_in  (serial_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a run and stream pat LSB first; returns just after the edge entering XFER.
    task automatic run_stream(input logic [5:0][11:0] pat, input bit hold_start, input string tag);
        int exp_bsel[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7, 0};
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_start got=%b exp=1", tag, busy);
        end
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            vectors++;
            if (bit_select !== 3'(exp_bsel[k])) begin
                miscompares++;
                $display("FAIL %s bit_select[%0d] got=%0d exp=%0d", tag, k, bit_select, exp_bsel[k]);
            end
            if (k >= 1) begin
                for (int r = 0; r < 6; r++) serial_in[r] = pat[r][k-1];
            end
        end
        tick();
        serial_in = '0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_in_xfer got=%b exp=1", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; serial_in = '0; res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, bit_select, res_valid} !== 5'b0 || res_data !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_state busy=%b bsel=%0d valid=%b data=%h exp all 0",
                     busy, bit_select, res_valid, res_data);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [5:0][11:0] pat;
        pat = '0;
        pat[0] = 12'h5A3;
        run_stream(pat, 1'b0, "basic");
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic valid_before_E14 got=%b exp=0", res_valid);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 72'h000_000_000_000_000_5A3 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic result valid=%b busy=%b data=%h exp valid=1 busy=0 data=%h",
                     res_valid, busy, res_data, 72'h5A3);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic valid_after_accept got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0][11:0] pa;
        logic [5:0][11:0] pb;
        pa = {12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666};
        pb = {12'hABC, 12'h000, 12'hFFF, 12'h801, 12'h07E, 12'hC3C};
        res_ready = 1'b0;
        run_stream(pa, 1'b0, "bp_a");
        tick();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== pa) begin
            miscompares++;
            $display("FAIL bp_a result valid=%b data=%h exp valid=1 data=%h", res_valid, res_data, pa);
        end
        run_stream(pb, 1'b0, "bp_b");
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b1 || res_valid !== 1'b1 || res_data !== pa) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] busy=%b valid=%b data=%h exp busy=1 valid=1 data=%h",
                         i, busy, res_valid, res_data, pa);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b1 || res_data !== pb || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_swap valid=%b busy=%b data=%h exp valid=1 busy=0 data=%h",
                     res_valid, busy, res_data, pb);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain valid got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_start_ignored();
        logic [5:0][11:0] pc;
        pc = {12'h0F0, 12'h123, 12'h456, 12'h789, 12'hFED, 12'h001};
        run_stream(pc, 1'b1, "busy_start");
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || res_valid !== 1'b1 || res_data !== pc) begin
            miscompares++;
            $display("FAIL busy_start result busy=%b valid=%b data=%h exp busy=0 valid=1 data=%h",
                     busy, res_valid, res_data, pc);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [5:0][11:0] pd;
        logic [5:0][11:0] ones;
        pd = {12'h00A, 12'h0B0, 12'hC00, 12'h5A5, 12'hA5A, 12'h3C3};
        ones = '1;
        run_stream(pd, 1'b0, "rst_pend");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            for (int r = 0; r < 6; r++) serial_in[r] = pd[r][k-1];
        end
        vectors++;
        if (bit_select !== 3'd5) begin
            miscompares++;
            $display("FAIL rst_mid pre_bsel got=%0d exp=5", bit_select);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, bit_select, res_valid} !== 5'b0 || res_data !== 72'd0) begin
            miscompares++;
            $display("FAIL rst_mid async busy=%b bsel=%0d valid=%b data=%h exp all 0",
                     busy, bit_select, res_valid, res_data);
        end
        serial_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        run_stream(ones, 1'b0, "rst_fresh");
        vectors++;
        if (res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_fresh stale_valid got=%b exp=0", res_valid);
        end
        tick();
        vectors++;
        if (res_valid !== 1'b1 || res_data !== {72{1'b1}}) begin
            miscompares++;
            $display("FAIL rst_fresh result valid=%b data=%h exp valid=1 data all ones", res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0][11:0] seq [3];
        seq[0] = {12'h101, 12'h202, 12'h303, 12'h404, 12'h505, 12'h606};
        seq[1] = {12'hF00, 12'h0F0, 12'h00F, 12'hAAA, 12'h555, 12'h800};
        seq[2] = {12'h7FF, 12'h001, 12'h246, 12'h8AC, 12'hE13, 12'h9B7};
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_stream(seq[i], 1'b0, "b2b");
            tick();
            vectors++;
            if (res_valid !== 1'b1 || res_data !== seq[i]) begin
                miscompares++;
                $display("FAIL b2b[%0d] result valid=%b data=%h exp valid=1 data=%h",
                         i, res_valid, res_data, seq[i]);
            end
            tick();
            vectors++;
            if (res_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b[%0d] single_delivery valid got=%b exp=0", i, res_valid);
            end
        end
        res_ready = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_result_deser.md
MULT_RESULT_DESER -- requirements
Module: mult_result_deser

Interface
REQ-001 Parameter MAX_OUT_LEN, default 6: number of serial result rows captured in parallel.
REQ-002 Parameter RESULT_WIDTH, default 12: bits collected per row per run, range 2..32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a new run; sampled only in IDLE.
REQ-006 busy  output  1  high in any state other than IDLE.
REQ-007 bit_select  output  3  bit-position select driven to the multiplier array; 0 marks the first bit of a run.
REQ-008 serial_in  input  MAX_OUT_LEN  per-row result bits from the multiplier, one bit per cycle, LSB first.
REQ-009 res_valid  output  1  res_data holds a complete result.
REQ-010 res_ready  input  1  consumer accepts res_data when high together with res_valid.
REQ-011 res_data  output  MAX_OUT_LEN*RESULT_WIDTH  row r at bits [r*RESULT_WIDTH +: RESULT_WIDTH], LSB = first bit received.

Function
REQ-012 FSM states: IDLE, RUN, LAST, XFER; encoding is free.
REQ-013 IDLE->RUN on start=1; bit counter cnt cleared to 0; shift register cleared.
REQ-014 bit_select = 0 while in RUN with cnt=0; min(cnt,7) while in RUN with cnt>0; 0 in all other states.
REQ-015 Multiplier latency is one register stage, so serial_in is sampled one cycle after the matching bit_select: at the first RUN edge nothing is captured; at each later RUN edge and at the LAST edge, serial_in is shifted in at the MSB of each row's shift register (shift right).
REQ-016 cnt increments at every RUN edge; RUN->LAST at the edge where cnt = RESULT_WIDTH-1.
REQ-017 LAST captures bit RESULT_WIDTH-1 and moves to XFER unconditionally.
REQ-018 XFER: if res_valid=0, or res_valid=1 and res_ready=1 in the same cycle, load the shift registers into res_data, set res_valid=1, and go to IDLE; otherwise remain in XFER, holding the shift registers.
REQ-019 res_valid clears at an edge with res_ready=1 unless a new result is loaded at that same edge (REQ-018); res_data is stable while res_valid=1 and res_ready=0.
REQ-020 Latency: start sampled at edge E0 -> res_valid high after edge E(RESULT_WIDTH+2) when the output register is free.
REQ-021 start is ignored while busy=1; start at the same edge that XFER returns to IDLE is ignored; start is accepted in IDLE even when res_valid=1 (one result can be held while the next run proceeds).
REQ-022 No arithmetic on the data: bits are stored unchanged; sign interpretation belongs to the consumer.

Reset
REQ-023 rst_n=0 forces IDLE, cnt=0, shift registers 0, res_data 0, res_valid 0, busy 0, bit_select 0, immediately and independently of clk.
REQ-024 Reset mid-run or in XFER discards the partial or pending result; no res_valid pulse follows the release of rst_n.
REQ-025 The first start after rst_n deasserts is honoured on the first rising edge with rst_n=1.

Structure
REQ-026 Shared package holds the FSM state type, the default MAX_OUT_LEN/RESULT_WIDTH constants, and the bit_select width (3) shared with the multiplier.
REQ-027 One sub-module, mult_row_shift: a RESULT_WIDTH-bit shift register with clear and shift-enable, instantiated once per row.

Verification
REQ-028 Reset then start, with serial_in row0 stream = 12'h5A3 LSB first and all other rows 0 -> res_data row0 = 12'h5A3, other rows 0; res_valid high after E14.
REQ-029 During a run -> bit_select sequence = 0,1,2,...,7,7,7,7,7 over the 12 RUN cycles, then 0.
REQ-030 res_ready held 0, result A pending, second run completes -> FSM holds in XFER with busy=1; res_ready pulsed -> A consumed, B loaded at the same edge, res_valid stays 1.
REQ-031 start pulsed while busy=1 -> no effect on cnt or bit_select sequence.
REQ-032 rst_n low at cnt=5 -> all outputs 0 asynchronously; after release, a fresh run with all rows = 12'hFFF gives res_data all ones.
REQ-033 Back-to-back runs with res_ready=1 -> each result delivered exactly once, with rows unchanged and in order.
